// File: rtl/rr_grant_fsm.sv
// rr_grant_fsm: round-robin arbiter sharing one FSM-driven resource
// between REQ_CNT requesters, with a rotating pointer and hold limit.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req         per-requester request level
//   done        current owner finished (sampled only while granting)
//   grant       registered one-hot grant
//   grant_valid registered OR of grant
//   grant_idx   owner index, 0 when no grant
//   timeout     one-cycle pulse when MAX_HOLD revokes a grant
//
// Optional macro RR_GRANT_BACK_TO_BACK_EN: on release, hand the grant
// straight to the next waiting requester with no IDLE bubble.

module rr_grant_fsm #(
  parameter int REQ_CNT  = 4,
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_CNT-1:0]         req,
  input  logic                       done,
  output logic [REQ_CNT-1:0]         grant,
  output logic                       grant_valid,
  output logic [$clog2(REQ_CNT)-1:0] grant_idx,
  output logic                       timeout
);

  localparam int IDX_W = $clog2(REQ_CNT);

  localparam bit HOLD_EN = (MAX_HOLD != 0);

  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

  localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(REQ_CNT - 1);

  localparam logic [REQ_CNT-1:0] ONE =
    {{(REQ_CNT-1){1'b0}}, 1'b1};

  if (REQ_CNT < 2 || REQ_CNT > 16) begin : g_bad_cnt
    $error("rr_grant_fsm: REQ_CNT out of range 2..16");
  end

  if ((2 ** HOLD_W) <= MAX_HOLD) begin : g_bad_hold
    $error("rr_grant_fsm: HOLD_W too narrow for MAX_HOLD");
  end

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t               r_state;
  state_t               w_state_n;
  logic [REQ_CNT-1:0]   r_grant;
  logic [REQ_CNT-1:0]   w_grant_n;
  logic                 r_valid;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_n;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     w_ptr_n;
  logic [HOLD_W-1:0]    r_hold;
  logic [HOLD_W-1:0]    w_hold_n;
  logic                 r_tmo;
  logic                 w_tmo_n;

  logic                 w_pick_ok;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_rel_done;
  logic                 w_rel_drop;
  logic                 w_rel_max;
  logic                 w_rel;
  logic [IDX_W-1:0]     w_ptr_inc;

`ifdef RR_GRANT_BACK_TO_BACK_EN
  logic                 w_b2b_ok;
  logic [IDX_W-1:0]     w_b2b_idx;
`endif

  // Scan from p upward, wrapping; returns {found, index}.
  function automatic logic [IDX_W:0] f_pick(
    input logic [REQ_CNT-1:0] r,
    input logic [IDX_W-1:0]   p
  );
    logic             found;
    logic [IDX_W-1:0] sel;
    int               k;
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < REQ_CNT; i++) begin
      k = int'(p) + i;
      if (k >= REQ_CNT) k = k - REQ_CNT;
      if (!found && r[k]) begin
        found = 1'b1;
        sel   = IDX_W'(k);
      end
    end
    return {found, sel};
  endfunction

  function automatic logic [IDX_W-1:0] f_inc(
    input logic [IDX_W-1:0] i
  );
    return (i == IDX_LAST) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    {w_pick_ok, w_pick_idx} = f_pick(req, r_ptr);
    w_ptr_inc  = f_inc(r_idx);
    w_rel_done = done;
    w_rel_drop = ~req[r_idx];
    w_rel_max  = HOLD_EN && (r_hold == HOLD_LAST);
    w_rel      = w_rel_done | w_rel_drop | w_rel_max;
  end

`ifdef RR_GRANT_BACK_TO_BACK_EN
  // Releasing owner is masked out so it cannot re-win immediately.
  always_comb begin
    {w_b2b_ok, w_b2b_idx} = f_pick(req & ~r_grant, w_ptr_inc);
  end
`endif

  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_idx_n   = r_idx;
    w_ptr_n   = r_ptr;
    w_hold_n  = r_hold;
    w_tmo_n   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_pick_ok) begin
          w_state_n = S_GRANT;
          w_grant_n = ONE << w_pick_idx;
          w_idx_n   = w_pick_idx;
          w_hold_n  = '0;
        end
      end
      S_GRANT: begin
        if (w_rel) begin
          w_state_n = S_IDLE;
          w_grant_n = '0;
          w_idx_n   = '0;
          w_ptr_n   = w_ptr_inc;
          w_hold_n  = '0;
          // Pulse only when the hold limit alone ended the grant.
          w_tmo_n   = w_rel_max & ~w_rel_done & ~w_rel_drop;
`ifdef RR_GRANT_BACK_TO_BACK_EN
          if (w_b2b_ok) begin
            w_state_n = S_GRANT;
            w_grant_n = ONE << w_b2b_idx;
            w_idx_n   = w_b2b_idx;
          end
`endif
        end else if (r_hold != HOLD_SAT) begin
          w_hold_n = r_hold + 1'b1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_grant_n = '0;
        w_idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_grant <= w_grant_n;
      r_valid <= |w_grant_n;
      r_idx   <= w_idx_n;
      r_ptr   <= w_ptr_n;
      r_hold  <= w_hold_n;
      r_tmo   <= w_tmo_n;
    end
  end

  assign grant       = r_grant;
  assign grant_valid = r_valid;
  assign grant_idx   = r_idx;
  assign timeout     = r_tmo;

  ap_onehot: assert property (
    @(posedge clk) $onehot0(r_grant)
  );

endmodule

// File: tb/tb_rr_grant_fsm.sv
// tb_rr_grant_fsm: directed self-checking bench for rr_grant_fsm.
// Default parameters; also follows RR_GRANT_BACK_TO_BACK_EN when set.

module tb_rr_grant_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_idx;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_grant_fsm #(
    .REQ_CNT (4),
    .MAX_HOLD(15),
    .HOLD_W  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(
    input string      tag,
    input logic [3:0] g,
    input logic [1:0] idx,
    input logic       tmo
  );
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(|g));
    chk({tag, ".idx"}, 32'(grant_idx), 32'(idx));
    chk({tag, ".tmo"}, 32'(timeout), 32'(tmo));
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    chk_out("reset", 4'b0000, 2'd0, 1'b0);

    // Single requester 2, then done with everyone requesting.
    req = 4'b0100;
    cyc();
    chk_out("g2", 4'b0100, 2'd2, 1'b0);
    cyc();
    chk_out("g2_hold", 4'b0100, 2'd2, 1'b0);
    req  = 4'b1111;
    done = 1'b1;
    cyc();
    done = 1'b0;
`ifdef RR_GRANT_BACK_TO_BACK_EN
    chk_out("g3_b2b", 4'b1000, 2'd3, 1'b0);
`else
    chk_out("rel2", 4'b0000, 2'd0, 1'b0);
    cyc();
    chk_out("g3_ptr", 4'b1000, 2'd3, 1'b0);
`endif

    // done held high: rotation 0,1,2,3,0; done in IDLE ignored.
    done = 1'b1;
    for (int k = 0; k < 5; k++) begin
`ifndef RR_GRANT_BACK_TO_BACK_EN
      cyc();
      chk_out("rot_gap", 4'b0000, 2'd0, 1'b0);
`endif
      cyc();
      chk_out("rot", 4'b0001 << (k % 4), 2'(k % 4), 1'b0);
    end
    done = 1'b0;

    // Owner 0 withdraws: release without timeout, ptr -> 1.
    req = 4'b0000;
    cyc();
    chk_out("withdraw0", 4'b0000, 2'd0, 1'b0);

    // Hold limit: grant exactly 15 cycles then timeout pulse.
    req = 4'b0001;
    cyc();
    chk_out("hold_c1", 4'b0001, 2'd0, 1'b0);
    for (int i = 2; i <= 15; i++) begin
      cyc();
      chk_out("hold_cn", 4'b0001, 2'd0, 1'b0);
    end
    cyc();
    chk_out("tmo", 4'b0000, 2'd0, 1'b1);
    cyc();
    chk_out("regrant0", 4'b0001, 2'd0, 1'b0);

    // done coinciding with hold expiry: no timeout.
    for (int i = 2; i <= 15; i++) cyc();
    chk_out("hold15", 4'b0001, 2'd0, 1'b0);
    done = 1'b1;
    cyc();
    done = 1'b0;
    chk_out("done_exp", 4'b0000, 2'd0, 1'b0);
    cyc();
    chk_out("regrant0b", 4'b0001, 2'd0, 1'b0);
    req = 4'b0000;
    cyc();
    chk_out("withdraw0b", 4'b0000, 2'd0, 1'b0);

    // Owner 1 drops with requester 3 waiting.
    req = 4'b1010;
    cyc();
    chk_out("g1", 4'b0010, 2'd1, 1'b0);
    cyc();
    req = 4'b1000;
    cyc();
`ifdef RR_GRANT_BACK_TO_BACK_EN
    chk_out("g3_drop_b2b", 4'b1000, 2'd3, 1'b0);
`else
    chk_out("drop1", 4'b0000, 2'd0, 1'b0);
    cyc();
    chk_out("g3_drop", 4'b1000, 2'd3, 1'b0);
`endif

    // Reset mid-grant, then fresh rotation from index 0.
    req = 4'b1111;
    cyc();
    chk_out("g3_pre_rst", 4'b1000, 2'd3, 1'b0);
    rst = 1'b1;
    cyc();
    chk_out("rst_mid", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    cyc();
    chk_out("post_rst", 4'b0001, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
